// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array input feeder.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Default configuration: 4 x 4 array of 32-bit MACs.
    localparam int DEF_N      = 4;
    localparam int DEF_DATA_W = 32;

    // Sizing for the default configuration.
    localparam int RUN_CYCLES = 3 * DEF_N - 2;
    localparam int IDX_W      = $clog2(DEF_N);
    localparam int T_W        = $clog2(3 * DEF_N);

    // Number of RUN cycles needed to drain a full skewed tile into an n x n array.
    function automatic int run_cycles(input int n);
        return 3 * n - 2;
    endfunction

    // Width of the RUN-cycle counter for an n x n array.
    function automatic int t_width(input int n);
        return $clog2(3 * n);
    endfunction

endpackage

// File: rtl/systolic_feeder_tile_buffer.sv
// N x N tile register file: one write port, synchronous clear, N independent read lanes.
module tile_buffer
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N      = DEF_N
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(N)-1:0]        wr_row,
    input  logic [$clog2(N)-1:0]        wr_col,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic [N*$clog2(N)-1:0]      rd_row,
    input  logic [N*$clog2(N)-1:0]      rd_col,
    output logic [N*DATA_W-1:0]         rd_data
);

    localparam int BUF_IDX_W = $clog2(N);

    logic [DATA_W-1:0] mem_r [N][N];

    // Element storage: cleared on reset, single element written per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mem_r[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_r[wr_row][wr_col] <= wr_data;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Each lane reads the element addressed by its own row/column pair.
    always_comb begin
        rd_data = '0;
        for (int l = 0; l < N; l++) begin
            rd_data[l*DATA_W +: DATA_W] =
                mem_r[rd_row[l*BUF_IDX_W +: BUF_IDX_W]][rd_col[l*BUF_IDX_W +: BUF_IDX_W]];
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Input-skew stage for an N x N systolic MAC array: buffers A and B tiles,
// clears the array, feeds diagonally skewed operands and flags final results.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N      = DEF_N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [$clog2(N)-1:0]   wr_row,
    input  logic [$clog2(N)-1:0]   wr_col,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   arr_rst,
    output logic [N*DATA_W-1:0]    a_out,
    output logic [N*DATA_W-1:0]    b_out
);

    localparam int LIDX_W = $clog2(N);
    localparam int LT_W   = t_width(N);
    localparam int LRUN   = run_cycles(N);

    state_e            state_r, state_nxt_s;
    logic [LT_W-1:0]   t_r, t_nxt_s;
    logic              busy_r, done_r, arr_rst_r;
    logic [N*DATA_W-1:0] a_out_r, b_out_r;

    logic              idle_s;
    logic              a_we_s, b_we_s;
    logic [N*LIDX_W-1:0] a_rd_row_s, a_rd_col_s, b_rd_row_s, b_rd_col_s;
    logic [N*DATA_W-1:0] a_rd_data_s, b_rd_data_s;
    logic [N*DATA_W-1:0] a_lane_s, b_lane_s;

    // The outputs lag the state by one cycle, so the visible done cycle is
    // still treated as busy: writes and start are taken only when both agree.
    assign idle_s = (state_r == IDLE) && !busy_r;
    assign a_we_s = wr_en && idle_s && (wr_sel == 1'b0);
    assign b_we_s = wr_en && idle_s && (wr_sel == 1'b1);

    tile_buffer #(.DATA_W(DATA_W), .N(N)) u_a_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (a_we_s),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .rd_row  (a_rd_row_s),
        .rd_col  (a_rd_col_s),
        .rd_data (a_rd_data_s)
    );

    tile_buffer #(.DATA_W(DATA_W), .N(N)) u_b_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (b_we_s),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .rd_row  (b_rd_row_s),
        .rd_col  (b_rd_col_s),
        .rd_data (b_rd_data_s)
    );

    // State and skew-counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            t_r     <= '0;
        end else begin
            state_r <= state_nxt_s;
            t_r     <= t_nxt_s;
        end
    end

    // Next-state logic: one clear cycle, 3N-2 feed cycles, one done cycle.
    always_comb begin
        state_nxt_s = state_r;
        t_nxt_s     = '0;
        case (state_r)
            IDLE: begin
                if (start && !busy_r) begin
                    state_nxt_s = CLEAR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLEAR: begin
                state_nxt_s = RUN;
            end
            RUN: begin
                if (t_r == LT_W'(LRUN - 1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                    t_nxt_s     = t_r + LT_W'(1);
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Skew addressing and validity masking: A lane i reads column t-i, B lane j reads row t-j.
    always_comb begin
        int diff_v;
        diff_v     = 0;
        a_rd_row_s = '0;
        a_rd_col_s = '0;
        b_rd_row_s = '0;
        b_rd_col_s = '0;
        a_lane_s   = '0;
        b_lane_s   = '0;
        for (int i = 0; i < N; i++) begin
            diff_v = int'(t_r) - i;
            a_rd_row_s[i*LIDX_W +: LIDX_W] = LIDX_W'(i);
            b_rd_col_s[i*LIDX_W +: LIDX_W] = LIDX_W'(i);
            if ((state_r == RUN) && (diff_v >= 0) && (diff_v < N)) begin
                a_rd_col_s[i*LIDX_W +: LIDX_W] = LIDX_W'(diff_v);
                b_rd_row_s[i*LIDX_W +: LIDX_W] = LIDX_W'(diff_v);
                a_lane_s[i*DATA_W +: DATA_W]   = a_rd_data_s[i*DATA_W +: DATA_W];
                b_lane_s[i*DATA_W +: DATA_W]   = b_rd_data_s[i*DATA_W +: DATA_W];
            end else begin
                a_rd_col_s[i*LIDX_W +: LIDX_W] = '0;
                b_rd_row_s[i*LIDX_W +: LIDX_W] = '0;
                a_lane_s[i*DATA_W +: DATA_W]   = '0;
                b_lane_s[i*DATA_W +: DATA_W]   = '0;
            end
        end
    end

    // Registered outputs decoded from the current state; lanes are zero outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            arr_rst_r <= 1'b0;
            a_out_r   <= '0;
            b_out_r   <= '0;
        end else begin
            busy_r    <= (state_r != IDLE);
            done_r    <= (state_r == DONE);
            arr_rst_r <= (state_r == CLEAR);
            a_out_r   <= a_lane_s;
            b_out_r   <= b_lane_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign arr_rst = arr_rst_r;
    assign a_out   = a_out_r;
    assign b_out   = b_out_r;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (N=4) with a behavioural 4x4 MAC array.
module tb_systolic_feeder;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic            wr_sel;
    logic [1:0]      wr_row;
    logic [1:0]      wr_col;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic            busy;
    logic            done;
    logic            arr_rst;
    logic [N*DW-1:0] a_out;
    logic [N*DW-1:0] b_out;

    int checks = 0;
    int errors = 0;

    systolic_feeder #(.DATA_W(DW), .N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .arr_rst (arr_rst),
        .a_out   (a_out),
        .b_out   (b_out)
    );

    always #5 clk = ~clk;

    // Behavioural output-stationary MAC array driven by the feeder.
    int c_m [4][4];
    int a_p [4][4];
    int b_p [4][4];
    int c_done [4][4];

    function automatic int lane(input logic [N*DW-1:0] v, input int l);
        return int'(v[l*DW +: DW]);
    endfunction

    function automatic int a_in(input int i, input int j);
        if (j == 0) return lane(a_out, i);
        else        return a_p[i][j-1];
    endfunction

    function automatic int b_in(input int i, input int j);
        if (i == 0) return lane(b_out, j);
        else        return b_p[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (rst || arr_rst) begin
                    c_m[i][j] <= 0;
                    a_p[i][j] <= 0;
                    b_p[i][j] <= 0;
                end else begin
                    c_m[i][j] <= c_m[i][j] + a_in(i, j) * b_in(i, j);
                    a_p[i][j] <= a_in(i, j);
                    b_p[i][j] <= b_in(i, j);
                end
            end
        end
    end

    // Captures per cycle of a feed, index = edges after the one that samples start.
    logic [N*DW-1:0] cap_a [0:41];
    logic [N*DW-1:0] cap_b [0:41];
    logic            cap_busy [0:41];

    typedef struct {
        int t;
        int a_exp [4];
        int b_exp [4];
    } skew_vec_t;

    skew_vec_t sv [5];

    task automatic chk(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int r, input int c, input int d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = r[1:0];
        wr_col  = c[1:0];
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Pulse start, record every cycle until one cycle after done (bounded).
    // inj_k >= 0 drives an A[0][0]=99 write plus a second start in that cycle.
    task automatic run_feed(input int inj_k, output int lat, output int nrst, output int ndone);
        lat   = -1;
        nrst  = 0;
        ndone = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            cap_a[k]    = a_out;
            cap_b[k]    = b_out;
            cap_busy[k] = busy;
            if (arr_rst) nrst++;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat    = k;
                    c_done = c_m;
                end
            end
            if (k == inj_k) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_row  = 2'd0;
                wr_col  = 2'd0;
                wr_data = 32'd99;
                start   = 1'b1;
            end else begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            if (lat >= 0 && k == lat + 1) break;
            tick();
        end
    endtask

    initial begin
        int lat, nrst, ndone;
        int acc;

        sv[0].t = 0; sv[0].a_exp = '{7, 0, 0, 0};     sv[0].b_exp = '{2, 0, 0, 0};
        sv[1].t = 1; sv[1].a_exp = '{1, 10, 0, 0};    sv[1].b_exp = '{2, 2, 0, 0};
        sv[2].t = 3; sv[2].a_exp = '{3, 12, 21, 30};  sv[2].b_exp = '{2, 2, 2, 2};
        sv[3].t = 6; sv[3].a_exp = '{0, 0, 0, 33};    sv[3].b_exp = '{0, 0, 0, 2};
        sv[4].t = 9; sv[4].a_exp = '{0, 0, 0, 0};     sv[4].b_exp = '{0, 0, 0, 0};

        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0;
        wr_data = 32'd0; start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state.
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_arr_rst", arr_rst, 1'b0);
        chk("rst_a_out", a_out, '0);
        chk("rst_b_out", b_out, '0);

        // Identity A times B[r][c] = 4r+c+1.
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                wr(1'b0, r, c, (r == c) ? 1 : 0);
                wr(1'b1, r, c, 4 * r + c + 1);
            end
        end
        run_feed(-1, lat, nrst, ndone);
        chk("id_done_latency", lat, 12);
        chk("id_arr_rst_pulses", nrst, 1);
        chk("id_done_pulses", ndone, 1);
        chk("id_busy_in_clear", cap_busy[1], 1'b1);
        chk("id_busy_after_done", cap_busy[13], 1'b0);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                chk($sformatf("id_c_%0d_%0d", r, c), c_done[r][c], 4 * r + c + 1);
            end
        end

        // All-twos tiles, then results must hold while idle.
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                wr(1'b0, r, c, 2);
                wr(1'b1, r, c, 2);
            end
        end
        run_feed(-1, lat, nrst, ndone);
        chk("two_done_latency", lat, 12);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                chk($sformatf("two_c_%0d_%0d", r, c), c_done[r][c], 16);
            end
        end
        repeat (20) tick();
        acc = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (c_m[r][c] != 16) acc++;
            end
        end
        chk("two_hold_20_cycles", acc, 0);

        // Skew pattern A[i][k] = 10i+k with A[0][0] = 7; write and start during RUN.
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                wr(1'b0, r, c, 10 * r + c);
            end
        end
        wr(1'b0, 0, 0, 7);
        run_feed(4, lat, nrst, ndone);
        chk("skew_done_latency", lat, 12);
        chk("skew_done_pulses", ndone, 1);
        chk("skew_idle_after_done", cap_busy[13], 1'b0);
        for (int v = 0; v < 5; v++) begin
            for (int l = 0; l < N; l++) begin
                chk($sformatf("skew_a_t%0d_l%0d", sv[v].t, l), lane(cap_a[sv[v].t + 2], l), sv[v].a_exp[l]);
                chk($sformatf("skew_b_t%0d_l%0d", sv[v].t, l), lane(cap_b[sv[v].t + 2], l), sv[v].b_exp[l]);
            end
        end

        // Back-to-back feed: old A[0][0] kept, no accumulation carried over.
        run_feed(-1, lat, nrst, ndone);
        chk("b2b_done_latency", lat, 12);
        chk("b2b_arr_rst_pulses", nrst, 1);
        chk("b2b_a00_kept", lane(cap_a[2], 0), 7);
        chk("b2b_c_0_0", c_done[0][0], 26);
        chk("b2b_c_1_2", c_done[1][2], 92);
        chk("b2b_c_3_3", c_done[3][3], 252);

        // Reset in the middle of RUN clears buffers and aborts the feed.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_a_out", a_out, '0);
        chk("mid_rst_b_out", b_out, '0);
        run_feed(-1, lat, nrst, ndone);
        chk("zero_done_latency", lat, 12);
        acc = 0;
        for (int k = 0; k <= 13; k++) begin
            if (cap_a[k] != '0 || cap_b[k] != '0) acc++;
        end
        chk("zero_lanes_all_zero", acc, 0);
        chk("zero_c_1_2", c_done[1][2], 0);
        chk("zero_c_3_3", c_done[3][3], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Input-skew stage that sits directly upstream of the N x N systolic array of MAC processing elements.
- Buffers one A tile and one B tile (N x N, DATA_W each), then drives the array's west edge (rows of A) and north edge (columns of B) with the diagonal skew the array needs.
- Issues the array reset that clears the accumulators before each tile, and flags when the array's out_c values are final.

Parameters:
- DATA_W, 32, element width; matches the MAC data width.
- N, 4, array dimension (tile is N x N); legal range 2..16.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  tile-buffer write strobe.
- wr_sel  in  1  0 selects the A buffer, 1 selects the B buffer.
- wr_row  in  $clog2(N)  element row index.
- wr_col  in  $clog2(N)  element column index.
- wr_data  in  DATA_W  element value.
- start  in  1  single-cycle request to feed the buffered tiles.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse; array results are final and remain stable until the next arr_rst.
- arr_rst  out  1  one-cycle pulse to the array's rst input.
- a_out  out  N*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W] and drives in_a of row i, column 0.
- b_out  out  N*DATA_W  lane j occupies bits [j*DATA_W +: DATA_W] and drives in_b of row 0, column j.

Behaviour:
- Reset: state IDLE, t=0, both buffers cleared to 0.
  - busy=0, done=0, arr_rst=0, a_out=0, b_out=0.
- All outputs are registered.
- Reset mid-operation has the same effect: the state machine aborts to IDLE and the buffers are cleared.
- Writes: accepted only when wr_en=1 and state is IDLE. A write sets buf[wr_sel][wr_row][wr_col] = wr_data. Writes in any other state are ignored.
- FSM states: IDLE, CLEAR, RUN, DONE.
  - IDLE -> CLEAR when start=1. start is ignored in every other state.
  - If wr_en and start are both asserted in IDLE, the write lands first and the feed uses the new value.
  - CLEAR (1 cycle): arr_rst=1, a_out=0, b_out=0. Next state is RUN with t=0.
  - RUN (3N-2 cycles, t = 0..3N-3, t increments by 1 per cycle):
    - a_out lane i = A[i][t-i] if 0 <= t-i < N, else 0.
    - b_out lane j = B[t-j][j] if 0 <= t-j < N, else 0.
    - After t = 3N-3 the next state is DONE.
  - DONE (1 cycle): done=1, a_out=0, b_out=0. Next state is IDLE.
- Timing rationale:
  - PE(i,j) consumes A[i][k] and B[k][j] together in cycle i+j+k.
  - The last product, at PE(N-1,N-1) in cycle 3N-3, is registered at the end of the final RUN cycle. Every out_c is therefore final in the DONE cycle.
- Latency: done asserts 3N cycles after the clock edge that samples start. For N=4 that is 12.
- Outside RUN, a_out and b_out are held at 0. Every in-flight operand pair is then zero-aligned, so array results stay stable indefinitely.
- Buffer contents persist across runs, so a tile can be re-fed without rewriting it.
- The block performs no arithmetic; values pass through unchanged at DATA_W.

Decomposition:
- Shared package systolic_pkg holds:
  - the state enum (IDLE, CLEAR, RUN, DONE);
  - localparam RUN_CYCLES = 3*N-2;
  - localparam IDX_W = $clog2(N);
  - localparam T_W = $clog2(3*N).
- One natural sub-module, tile_buffer:
  - N x N register file of DATA_W entries with one write port, synchronous clear on rst, and a combinational N-lane read (one element per lane).
  - Instantiated twice: A is read by row with column index t-i; B is read by column with row index t-j.
  - Skew-index validity masking stays in systolic_feeder.

Test Plan:
- Reset, N=4: assert rst for 2 cycles mid-RUN -> next cycle busy=0, a_out=0, b_out=0; a subsequent start with no writes feeds all zeros.
- Identity A, B[r][c] = 4r+c+1, start -> arr_rst high exactly 1 cycle; done high exactly 12 cycles after the start edge; a 4x4 MAC array model holds out_c[r][c] = 4r+c+1 in the done cycle.
- A = B = all 2s -> every out_c = 16 at done; out_c is unchanged 20 cycles later with the feeder idle.
- Skew check, A[i][k] = 10i+k -> during RUN t=3, lane 0 = 3, lane 1 = 12, lane 2 = 21, lane 3 = 30; at t=0, lanes 1..3 = 0; at t=9, all lanes = 0.
- Write during busy (wr_en=1, A[0][0] = 99) and a second start during RUN -> both ignored; the run completes on schedule; a second feed still uses the old A[0][0].
- Back-to-back: start in the cycle after done -> a second arr_rst pulse occurs and the results match a fresh computation, with no accumulation carried over from the first run.
